// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-flop synchroniser followed by a stability-window debouncer
// Optional macro EDGE_PULSE_EN adds registered rise_p/fall_p edge pulses.
module debounce_sync #(
  parameter int   STABLE_CYCLES = 16,
  parameter int   CNT_W         = 5,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic db_out,
  output logic busy
`ifdef EDGE_PULSE_EN
  ,
  output logic rise_p,
  output logic fall_p
`endif
);

  typedef enum logic {STABLE, PENDING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_cfg_err
    $error("debounce_sync: STABLE_CYCLES=%0d does not fit CNT_W=%0d", STABLE_CYCLES, CNT_W);
  end

  logic             sync1;
  logic             sync2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      db_out <= RESET_LEVEL;
      state  <= STABLE;
      cnt    <= '0;
`ifdef EDGE_PULSE_EN
      rise_p <= 1'b0;
      fall_p <= 1'b0;
`endif
    end else begin
      sync1 <= din;
      sync2 <= sync1;
`ifdef EDGE_PULSE_EN
      rise_p <= 1'b0;
      fall_p <= 1'b0;
`endif
      case (state)
        STABLE: begin
          if (sync2 != db_out) begin
            state <= PENDING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PENDING: begin
          if (sync2 == db_out) begin
            // run broken before the window filled: treat as a glitch
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            db_out <= ~db_out;
            state  <= STABLE;
            cnt    <= '0;
`ifdef EDGE_PULSE_EN
            rise_p <= ~db_out;
            fall_p <= db_out;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == PENDING);

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - scoreboard bench for debounce_sync (default and STABLE_CYCLES=2 instances)
// Optional macro EDGE_PULSE_EN also checks rise_p/fall_p.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic db_a, busy_a, db_b, busy_b;
  logic rise_a, fall_a, rise_b, fall_b;

  always #5 clk = ~clk;

`ifdef EDGE_PULSE_EN
  debounce_sync #(.STABLE_CYCLES(16), .CNT_W(5), .RESET_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din), .db_out(db_a), .busy(busy_a),
    .rise_p(rise_a), .fall_p(fall_a));
  debounce_sync #(.STABLE_CYCLES(2), .CNT_W(2), .RESET_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din), .db_out(db_b), .busy(busy_b),
    .rise_p(rise_b), .fall_p(fall_b));
`else
  debounce_sync #(.STABLE_CYCLES(16), .CNT_W(5), .RESET_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din), .db_out(db_a), .busy(busy_a));
  debounce_sync #(.STABLE_CYCLES(2), .CNT_W(2), .RESET_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din), .db_out(db_b), .busy(busy_b));
  assign rise_a = 1'b0;
  assign fall_a = 1'b0;
  assign rise_b = 1'b0;
  assign fall_b = 1'b0;
`endif

  typedef struct {
    logic s1, s2, db, rise, fall;
    int   run;
  } mstate_t;

  typedef struct {
    logic db, busy, rise, fall;
  } exp_t;

  mstate_t ma, mb;
  exp_t    qa[$];
  exp_t    qb[$];
  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  int      rises = 0;
  int      falls = 0;

  function automatic mstate_t mreset();
    mstate_t m;
    m.s1 = 1'b0; m.s2 = 1'b0; m.db = 1'b0;
    m.rise = 1'b0; m.fall = 1'b0; m.run = 0;
    return m;
  endfunction

  // run counts consecutive edges on which the synchronised level disagreed with db
  function automatic mstate_t mstep(mstate_t m, logic d, int s);
    mstate_t n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (m.s2 != m.db) begin
      n.run = m.run + 1;
      if (n.run == s) begin
        n.db   = ~m.db;
        n.run  = 0;
        n.rise = n.db;
        n.fall = ~n.db;
      end
    end else begin
      n.run = 0;
    end
    n.s2 = m.s1;
    n.s1 = d;
    return n;
  endfunction

  function automatic exp_t mexp(mstate_t m);
    exp_t e;
    e.db = m.db; e.busy = (m.run > 0); e.rise = m.rise; e.fall = m.fall;
    return e;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic push_and_check();
    exp_t ea, eb;
    qa.push_back(mexp(ma));
    qb.push_back(mexp(mb));
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    check_bit("a_db", db_a, ea.db);
    check_bit("a_busy", busy_a, ea.busy);
    check_bit("b_db", db_b, eb.db);
    check_bit("b_busy", busy_b, eb.busy);
`ifdef EDGE_PULSE_EN
    check_bit("a_rise", rise_a, ea.rise);
    check_bit("a_fall", fall_a, ea.fall);
    check_bit("b_rise", rise_b, eb.rise);
    check_bit("b_fall", fall_b, eb.fall);
    if (rise_a) rises++;
    if (fall_a) falls++;
`endif
  endtask

  task automatic cycle(input logic d, input logic r);
    @(negedge clk);
    din = d;
    rst = r;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mstep(ma, d, 16);
      mb = mstep(mb, d, 2);
    end
    push_and_check();
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) cycle(d, 1'b1);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("async_db", db_a, 1'b0);
    check_bit("async_busy", busy_a, 1'b0);
    ma = mreset();
    mb = mreset();
    @(posedge clk);
    cyc++;
    push_and_check();
  endtask

  initial begin
    int guard;
    ma = mreset();
    mb = mreset();

    // reset held with din=1, then release and let both instances qualify the level
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    hold(1'b1, 25);
    hold(1'b0, 25);

    // short pulse from idle 0
    rises = 0;
    hold(1'b1, 5);
    hold(1'b0, 25);
`ifdef EDGE_PULSE_EN
    check_bit("pulse_no_rise", (rises == 0), 1'b1);
`endif

    // din toggling every 3 cycles
    for (int i = 0; i < 200; i++) cycle(((i / 3) % 2) != 0, 1'b1);
    hold(1'b0, 25);

    // clean 0->1 then 1->0 forty cycles later
    rises = 0;
    falls = 0;
    hold(1'b1, 40);
    hold(1'b0, 40);
`ifdef EDGE_PULSE_EN
    check_bit("clean_one_rise", (rises == 1), 1'b1);
    check_bit("clean_one_fall", (falls == 1), 1'b1);
`endif

    // reset mid-qualification at cnt=10
    hold(1'b0, 10);
    guard = 0;
    while (ma.run != 10 && guard < 40) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    check_bit("reach_cnt10", (ma.run == 10), 1'b1);
    async_reset_pulse();
    hold(1'b1, 25);

    // single-sample glitch and clean step for the short-window instance
    hold(1'b0, 25);
    hold(1'b1, 1);
    hold(1'b0, 10);
    hold(1'b1, 6);
    hold(1'b0, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
